// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type, minimum ratio and phase-length helper for clk_div_gen.
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    localparam int unsigned MIN_DIV = 2;
    function automatic int unsigned high_len(input int unsigned n);
        return (n + 32'd1) / 32'd2;
    endfunction
endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: period counter, boundary detect and registered divided clock.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 idle,
    input  logic [DIV_WIDTH-1:0] n,
    output logic                 last,
    output logic                 o
);
    logic [DIV_WIDTH-1:0] cnt;
    assign last = cnt == n - DIV_WIDTH'(1);
    // o is computed for the cycle being entered, so it always matches the new cnt
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            o   <= 1'b0;
        end else if (idle || last) begin
            cnt <= '0;
            o   <= 1'b1;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
            o   <= 32'(cnt) + 32'd1 < high_len(32'(n));
        end
    end
endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: glitch-free programmable clock divider feeding a global clock buffer.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 EN,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 DIV_REQ,
    output logic                 DIV_ACK,
    output logic                 DIV_BUSY,
    output logic                 ACTIVE,
    output logic                 O
);
    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] div_cur, div_nxt, div_in;
    logic                 last, take;
    always_comb begin
        div_in    = (DIV < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : DIV;
        take      = DIV_REQ && !DIV_BUSY;
        state_nxt = EN ? RUN : (state == RUN) ? STOP : (state == STOP && !last) ? STOP : IDLE;
    end
    always_ff @(posedge C) begin
        if (R) begin
            state    <= IDLE;
            ACTIVE   <= 1'b0;
            div_cur  <= DIV_WIDTH'(DEFAULT_DIV);
            div_nxt  <= DIV_WIDTH'(DEFAULT_DIV);
            DIV_BUSY <= 1'b0;
            DIV_ACK  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ACTIVE  <= state_nxt != IDLE;
            DIV_ACK <= 1'b0;
            if (state == IDLE) begin
                if (take) begin
                    div_cur <= div_in;
                    DIV_ACK <= 1'b1;
                end
            end else if (last && DIV_BUSY) begin
                div_cur  <= div_nxt;
                DIV_BUSY <= 1'b0;
                DIV_ACK  <= 1'b1;
            end else if (take) begin
                // a capture on the boundary edge waits for the following boundary
                div_nxt  <= div_in;
                DIV_BUSY <= 1'b1;
            end
        end
    end
    clk_div_counter #(.DIV_WIDTH(DIV_WIDTH)) u_counter (
        .clk (C),
        .rst (R),
        .en  (state_nxt != IDLE),
        .idle(state == IDLE),
        .n   (div_cur),
        .last(last),
        .o   (O)
    );
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Programmable fabric clock divider. Generates a registered divided clock on O that drives the I pin of the global clock buffer directly downstream.
- Divide ratio changes are glitch-free: a new ratio takes effect only on a period boundary, never mid-pulse.
- Start and stop complete whole periods, so the buffer never receives a runt pulse.

Parameters:
- DIV_WIDTH, 8: width of the divide-ratio bus.
- DEFAULT_DIV, 2: ratio loaded at reset. Must be >= 2 and < 2**DIV_WIDTH.

Ports:
- C  input  1  source clock; all logic is on the rising edge.
- R  input  1  synchronous reset, active-high.
- EN  input  1  run request (level).
- DIV  input  DIV_WIDTH  requested divide ratio N; sampled with DIV_REQ.
- DIV_REQ  input  1  ratio-change request, single-cycle strobe.
- DIV_ACK  output  1  one-cycle pulse when the new ratio is applied.
- DIV_BUSY  output  1  a ratio change is pending.
- ACTIVE  output  1  generator running (state RUN or STOP).
- O  output  1  divided clock, registered, to the global clock buffer input.

Behaviour:
- Reset (R=1 at an edge):
  - state=IDLE, cnt=0, div_cur=DEFAULT_DIV, pending cleared.
  - O=0, ACTIVE=0, DIV_ACK=0, DIV_BUSY=0.
  - R has priority over every other input, including mid-period; O drops to 0 on the next edge.
- Ratio clamp: any sampled DIV < 2 is treated as 2. Period = N cycles; high phase H = ceil(N/2) cycles, low phase = N-H cycles.
  - N=2: 1 cycle high, 1 low. N=5: 3 high, 2 low.
- Counter: cnt runs 0..N-1 in RUN/STOP.
  - O=1 while cnt<H, else 0.
  - The boundary is the cycle with cnt==N-1; the next cycle is cnt=0 of the next period.
- States:
  - IDLE: O=0. EN=1 sampled -> RUN. The first high cycle of O is the cycle after the sampling edge (cnt=0).
  - RUN: EN=0 sampled -> STOP. The counter continues unchanged.
  - STOP: finishes the current period. At the boundary, goes to IDLE (O=0, ACTIVE=0, cnt=0). EN=1 sampled before the boundary -> back to RUN with no discontinuity on O.
- Ratio change:
  - DIV_REQ=1 with DIV_BUSY=0 captures the clamped DIV into div_nxt.
  - In IDLE: div_cur is updated at the same edge, and DIV_ACK pulses the following cycle. DIV_BUSY never asserts.
  - In RUN/STOP: DIV_BUSY=1 from the next cycle. At the boundary edge, div_cur<=div_nxt, DIV_BUSY<=0 and DIV_ACK<=1 (one cycle). The following period uses the new N.
  - DIV_REQ while DIV_BUSY=1 is ignored: no capture, no ACK.
  - A request captured in the same cycle as the boundary is applied at the next boundary, not the current one.
- STOP reaching its boundary with a pending change: the change is applied at that edge, then the block enters IDLE.
- Simultaneous EN=1 and DIV_REQ=1 in IDLE: both take effect. The first period uses the new N.
- Width: cnt is DIV_WIDTH bits. No overflow, since N <= 2**DIV_WIDTH-1.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum (IDLE, RUN, STOP);
  - MIN_DIV=2;
  - a function high_len(N) returning ceil(N/2).
- One sub-module, clk_div_counter, contains the period counter, boundary detect and O register. The FSM and ratio handshake stay in the top.
- No combinational path from any input to O.

Test Plan:
- Reset, then EN=1 with DEFAULT_DIV=2:
  - O toggles 1,0,1,0 starting the cycle after EN is sampled; ACTIVE=1.
  - R=1 mid-high-phase -> O=0, ACTIVE=0 next cycle.
- Odd ratio: in IDLE, DIV=5 with DIV_REQ -> DIV_ACK next cycle. EN=1 -> O pattern 1,1,1,0,0 repeating.
- Change in flight: running at N=4, DIV=6 strobed at cnt=1.
  - DIV_BUSY=1 until the boundary.
  - Current period completes as 1,1,0,0.
  - DIV_ACK pulses, then the next period is 1,1,1,0,0,0.
  - A second DIV_REQ while busy produces no ACK.
- Stop and resume: N=6, EN=0 at cnt=1 -> period completes, O=0, ACTIVE=0 after the boundary. Repeat with EN re-asserted at cnt=4 -> O continues without a gap.
- Clamp: DIV=0 and DIV=1 requests -> behaves as N=2. DIV=255 (DIV_WIDTH=8) -> 128 high, 127 low.
- Boundary race: DIV_REQ at cnt==N-1 -> new ratio applied one full period later; DIV_ACK timing checked.
